// File: rtl/mmio_gpio_bank.sv
// ---------------------------------------------------------------------------
// mmio_gpio_bank
//
// Memory-mapped GPIO bank for a simple CPU load/store port. The bank
// provides synchronised input channels with per-channel change detection,
// registered output channels, and a level interrupt.
//
// Register map, as word offsets from BASE_ADDR (block selected when
// addr[31:5] == BASE_ADDR[31:5]):
//   0x00+k  IN_k       RO   synchronised input k, zero-extended
//   0x08+k  OUT_k      RW   output k, OUT_W bits
//   0x10    EDGE_STAT  W1C  bit k set on any change of input k
//   0x11    IRQ_EN     RW   NUM_IN bits
//   0x12    CFG        RO   {NUM_IN, NUM_OUT, IN_W, OUT_W} as bytes
// Other offsets, and absent channels, read as 0 and ignore writes.
//
// Ports:
//   clk       single clock, all state on the rising edge
//   rst       synchronous, active-high reset
//   addr      word address from the MEM stage
//   wr_en     store strobe
//   wr_data   store data
//   rd_en     load strobe
//   rd_data   load data, valid one cycle after rd_en
//   rd_valid  rd_data qualifier
//   gpio_in   asynchronous inputs, channel k = [k*IN_W +: IN_W]
//   gpio_out  registered outputs, channel k = [k*OUT_W +: OUT_W]
//   irq       level interrupt, |(EDGE_STAT & IRQ_EN)
// ---------------------------------------------------------------------------
module mmio_gpio_bank #(
    parameter int          NUM_IN    = 1,
    parameter int          NUM_OUT   = 1,
    parameter int          IN_W      = 8,
    parameter int          OUT_W     = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              addr,
    input  logic                     wr_en,
    input  logic [31:0]              wr_data,
    input  logic                     rd_en,
    output logic [31:0]              rd_data,
    output logic                     rd_valid,
    input  logic [NUM_IN*IN_W-1:0]   gpio_in,
    output logic [NUM_OUT*OUT_W-1:0] gpio_out,
    output logic                     irq
);

    localparam logic [4:0]  OFF_EDGE_STAT = 5'h10;
    localparam logic [4:0]  OFF_IRQ_EN    = 5'h11;
    localparam logic [4:0]  OFF_CFG       = 5'h12;
    localparam logic [31:0] CFG_VALUE     = {8'(NUM_IN), 8'(NUM_OUT), 8'(IN_W), 8'(OUT_W)};

    // Input path: two synchroniser stages plus the previous-value stage
    // used for change detection.
    logic [NUM_IN*IN_W-1:0]   r_sync1;
    logic [NUM_IN*IN_W-1:0]   r_sync2;
    logic [NUM_IN*IN_W-1:0]   r_prev;
    logic [1:0]               r_arm;
    logic [NUM_IN-1:0]        r_edge_stat;
    logic [NUM_IN-1:0]        r_irq_en;
    logic [NUM_OUT*OUT_W-1:0] r_out;
    logic [31:0]              r_rd_data;
    logic                     r_rd_valid;

    logic [4:0]        w_off;
    logic              w_sel;
    logic              w_wr;
    logic              w_rd;
    logic [NUM_IN-1:0] w_chan_edge;
    logic [NUM_IN-1:0] w_edge_set;
    logic [NUM_IN-1:0] w_edge_clr;
    logic [NUM_IN-1:0] w_edge_nxt;
    logic [31:0]       w_rd_mux;
    logic              w_unused_wr_data;

    assign w_off = addr[4:0];
    assign w_sel = (addr[31:5] == BASE_ADDR[31:5]);
    assign w_wr  = wr_en & w_sel;
    assign w_rd  = rd_en & w_sel;

    // Only the low register-width bits of a store are ever used.
    assign w_unused_wr_data = ^wr_data;

    // A channel has changed when any of its synchronised bits differs from
    // the value captured one cycle earlier.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_chan_edge = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_chan_edge[k] = |(r_sync2[k*IN_W +: IN_W] ^ r_prev[k*IN_W +: IN_W]);
        end
    end

    // The stages come out of reset at 0 while the pins may already sit at
    // a non-zero level; the arm counter masks the resulting false edges
    // until that value has flushed through to r_prev.
    assign w_edge_set = (r_arm == 2'd3) ? w_chan_edge : '0;
    assign w_edge_clr = (w_wr && (w_off == OFF_EDGE_STAT)) ? wr_data[NUM_IN-1:0] : '0;
    // A new edge wins over a same-cycle write-1-to-clear, so no change is lost.
    assign w_edge_nxt = (r_edge_stat & ~w_edge_clr) | w_edge_set;

    // Read mux over the current register values. It is sampled at the same
    // edge that applies any concurrent write, so a same-cycle read returns
    // the pre-write contents.
    always_comb begin
        w_rd_mux = '0;
        if (w_off[4:3] == 2'b00) begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (w_off[2:0] == 3'(k)) begin
                    w_rd_mux[IN_W-1:0] = r_sync2[k*IN_W +: IN_W];
                end
            end
        end else if (w_off[4:3] == 2'b01) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (w_off[2:0] == 3'(k)) begin
                    w_rd_mux[OUT_W-1:0] = r_out[k*OUT_W +: OUT_W];
                end
            end
        end else if (w_off == OFF_EDGE_STAT) begin
            w_rd_mux[NUM_IN-1:0] = r_edge_stat;
        end else if (w_off == OFF_IRQ_EN) begin
            w_rd_mux[NUM_IN-1:0] = r_irq_en;
        end else if (w_off == OFF_CFG) begin
            w_rd_mux = CFG_VALUE;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so each
    // register samples the pre-edge value of every other register.
    // NOTE: the output register array is a handful of flops, not a RAM, so
    // it is reset along with everything else and gpio_out is 0 from reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_prev      <= '0;
            r_arm       <= 2'd0;
            r_edge_stat <= '0;
            r_irq_en    <= '0;
            r_out       <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_sync1     <= gpio_in;
            r_sync2     <= r_sync1;
            r_prev      <= r_sync2;
            if (r_arm != 2'd3) begin
                r_arm <= r_arm + 2'd1;
            end
            r_edge_stat <= w_edge_nxt;

            if (w_wr && (w_off == OFF_IRQ_EN)) begin
                r_irq_en <= wr_data[NUM_IN-1:0];
            end
            for (int k = 0; k < NUM_OUT; k++) begin
                if (w_wr && (w_off == {2'b01, 3'(k)})) begin
                    r_out[k*OUT_W +: OUT_W] <= wr_data[OUT_W-1:0];
                end
            end

            r_rd_valid <= w_rd;
            r_rd_data  <= w_rd ? w_rd_mux : 32'h0;
        end
    end

    assign gpio_out = r_out;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign irq      = |(r_edge_stat & r_irq_en);

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// ---------------------------------------------------------------------------
// tb_mmio_gpio_bank
//
// Two instances share clock, reset and the load/store bus:
//   u_dut1  default parameters (1 input, 1 output)
//   u_dut2  NUM_IN=4, NUM_OUT=2
// Every issued read pushes its expected result (and expected return cycle)
// onto a queue; a negedge monitor pops and compares whenever rd_valid is
// seen and flags reads that never return or data that was not requested.
// ---------------------------------------------------------------------------
module tb_mmio_gpio_bank;

    typedef struct {
        logic [8*12-1:0] name;
        logic [31:0]     e1;
        logic            c2;
        logic [31:0]     e2;
        int              cyc;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'h0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic        rd_en = 1'b0;
    logic [7:0]  gpio_in = 8'h00;
    logic [31:0] gpio_in2 = 32'h4433_2211;

    logic [31:0] rd_data1;
    logic        rd_valid1;
    logic [9:0]  gpio_out1;
    logic        irq1;
    logic [31:0] rd_data2;
    logic        rd_valid2;
    logic [19:0] gpio_out2;
    logic        irq2;

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    rd_exp_t sb[$];
    rd_exp_t it;

    mmio_gpio_bank u_dut1 (
        .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .gpio_in(gpio_in), .gpio_out(gpio_out1), .irq(irq1)
    );

    mmio_gpio_bank #(.NUM_IN(4), .NUM_OUT(2)) u_dut2 (
        .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .gpio_in(gpio_in2), .gpio_out(gpio_out2), .irq(irq2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-response monitor.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %0s: rd_valid=0 at expected cycle %0d, required 1", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (rd_valid1 === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_valid_spurious: rd_valid=1 rd_data=%h, required rd_valid=0", rd_data1);
            end else begin
                it = sb.pop_front();
                if (it.cyc != cyc) begin
                    errors++;
                    $display("FAIL %0s_latency: returned cycle %0d, required %0d", it.name, cyc, it.cyc);
                end else if (rd_data1 !== it.e1) begin
                    errors++;
                    $display("FAIL %0s: dut1 rd_data=%h, required %h", it.name, rd_data1, it.e1);
                end
                if (it.c2) begin
                    checks++;
                    if (rd_valid2 !== 1'b1 || rd_data2 !== it.e2) begin
                        errors++;
                        $display("FAIL %0s: dut2 rd_valid=%b rd_data=%h, required 1 %h",
                                 it.name, rd_valid2, rd_data2, it.e2);
                    end
                end
            end
        end
    end

    // ---------------- bus helpers (take effect immediately) ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_idle();
        wr_en = 1'b0; rd_en = 1'b0; addr = 32'h0; wr_data = 32'h0;
    endtask

    task automatic set_wr(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; rd_en = 1'b0; addr = a; wr_data = d;
    endtask

    task automatic push_exp(input logic [8*12-1:0] nm, input logic [31:0] e1,
                            input logic c2, input logic [31:0] e2);
        rd_exp_t x;
        x.name = nm; x.e1 = e1; x.c2 = c2; x.e2 = e2; x.cyc = cyc + 1;
        sb.push_back(x);
    endtask

    task automatic set_rd(input logic [31:0] a, input logic [8*12-1:0] nm,
                          input logic [31:0] e1, input logic [31:0] e2);
        wr_en = 1'b0; rd_en = 1'b1; addr = a; wr_data = 32'h0;
        push_exp(nm, e1, 1'b1, e2);
    endtask

    // ------------------------------- tests ---------------------------------
    task automatic test_reset();
        tick(); rst = 1'b1; set_idle(); gpio_in = 8'h00;
        tick(); tick();
        checks++;
        if (rd_valid1 !== 1'b0 || rd_data1 !== 32'h0 || gpio_out1 !== 10'h0 || irq1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut1: rd_valid=%b rd_data=%h gpio_out=%h irq=%b, required all 0",
                     rd_valid1, rd_data1, gpio_out1, irq1);
        end
        checks++;
        if (rd_valid2 !== 1'b0 || rd_data2 !== 32'h0 || gpio_out2 !== 20'h0 || irq2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut2: rd_valid=%b rd_data=%h gpio_out=%h irq=%b, required all 0",
                     rd_valid2, rd_data2, gpio_out2, irq2);
        end
        rst = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_out_write();
        tick(); set_wr(32'h108, 32'h3FF);
        tick(); set_idle();
        checks++;
        if (gpio_out1 !== 10'h3FF || gpio_out2 !== 20'h003FF) begin
            errors++;
            $display("FAIL out_write: gpio_out1=%h gpio_out2=%h, required 3ff 003ff", gpio_out1, gpio_out2);
        end
        set_rd(32'h108, "out0_rd", 32'h3FF, 32'h3FF);
        tick(); set_wr(32'h108, 32'hFFFF_F001);
        tick(); set_idle();
        checks++;
        if (gpio_out1 !== 10'h001) begin
            errors++;
            $display("FAIL out_mask: gpio_out1=%h, required 001", gpio_out1);
        end
        set_rd(32'h108, "out0_mask", 32'h001, 32'h001);
        tick(); set_wr(32'h109, 32'h0000_12AB);
        tick(); set_idle();
        checks++;
        if (gpio_out1 !== 10'h001 || gpio_out2 !== 20'hAAC01) begin
            errors++;
            $display("FAIL out1_write: gpio_out1=%h gpio_out2=%h, required 001 aac01", gpio_out1, gpio_out2);
        end
        set_rd(32'h109, "out1_rd", 32'h0, 32'h2AB);
    endtask

    // Back-to-back reads across the whole map, including absent channels.
    task automatic test_map();
        tick(); set_rd(32'h112, "cfg",       32'h0101_080A, 32'h0402_080A);
        tick(); set_rd(32'h10A, "out2_absent", 32'h0, 32'h0);
        tick(); set_rd(32'h105, "in5_absent", 32'h0, 32'h0);
        tick(); set_rd(32'h100, "in0",       32'h0, 32'h11);
        tick(); set_rd(32'h101, "in1",       32'h0, 32'h22);
        tick(); set_rd(32'h103, "in3",       32'h0, 32'h44);
        tick(); set_rd(32'h113, "unmapped13", 32'h0, 32'h0);
        tick(); set_rd(32'h11F, "unmapped1f", 32'h0, 32'h0);
        tick(); set_rd(32'h110, "stat_armed", 32'h0, 32'h0);
        tick(); set_wr(32'h10A, 32'h155);
        tick(); set_idle();
        checks++;
        if (gpio_out1 !== 10'h001 || gpio_out2 !== 20'hAAC01) begin
            errors++;
            $display("FAIL absent_write: gpio_out1=%h gpio_out2=%h, required 001 aac01", gpio_out1, gpio_out2);
        end
    endtask

    task automatic test_unselected();
        tick(); wr_en = 1'b0; rd_en = 1'b1; addr = 32'h0000_0200;
        tick(); wr_en = 1'b1; rd_en = 1'b0; addr = 32'h0000_0208; wr_data = 32'h3FF;
        checks++;
        if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL unsel_read: rd_valid1=%b rd_valid2=%b, required 0 0", rd_valid1, rd_valid2);
        end
        tick(); wr_en = 1'b0; rd_en = 1'b1; addr = 32'h0000_0128;
        tick(); set_idle();
        checks++;
        if (gpio_out1 !== 10'h001 || rd_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL unsel_write: gpio_out1=%h rd_valid1=%b, required 001 0", gpio_out1, rd_valid1);
        end
    endtask

    task automatic test_edge_irq();
        tick(); set_wr(32'h111, 32'hFFFF_FFFF);
        tick(); set_rd(32'h111, "irq_en_mask", 32'h1, 32'hF);
        tick(); gpio_in = 8'hA5; set_rd(32'h100, "in0_sync0", 32'h0, 32'h11);
        tick(); set_rd(32'h100, "in0_sync1", 32'h0, 32'h11);
        checks++;
        if (irq1 !== 1'b0) begin
            errors++;
            $display("FAIL irq_early: irq1=%b, required 0", irq1);
        end
        tick(); set_rd(32'h100, "in0_sync2", 32'hA5, 32'h11);
        tick(); set_idle();
        checks++;
        if (irq1 !== 1'b1 || irq2 !== 1'b0) begin
            errors++;
            $display("FAIL irq_set: irq1=%b irq2=%b, required 1 0", irq1, irq2);
        end
        set_rd(32'h110, "stat_set", 32'h1, 32'h0);
        tick(); set_wr(32'h110, 32'h1);
        tick(); set_idle();
        checks++;
        if (irq1 !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: irq1=%b, required 0", irq1);
        end
        set_rd(32'h110, "stat_clr", 32'h0, 32'h0);
    endtask

    task automatic test_reset_hold();
        tick(); rst = 1'b1; set_idle(); gpio_in = 8'hFF;
        tick(); tick(); rst = 1'b0; set_wr(32'h111, 32'h1);
        repeat (6) begin tick(); set_idle(); end
        checks++;
        if (irq1 !== 1'b0 || irq2 !== 1'b0) begin
            errors++;
            $display("FAIL hold_irq: irq1=%b irq2=%b, required 0 0", irq1, irq2);
        end
        set_rd(32'h110, "hold_stat", 32'h0, 32'h0);
        tick(); set_rd(32'h100, "hold_in0", 32'hFF, 32'h11);
    endtask

    task automatic test_w1c_race();
        tick(); set_idle(); gpio_in = 8'h00;
        repeat (4) tick();
        checks++;
        if (irq1 !== 1'b1) begin
            errors++;
            $display("FAIL race_pre: irq1=%b, required 1", irq1);
        end
        gpio_in = 8'h5A;
        tick();
        tick(); set_wr(32'h110, 32'h1);
        tick(); set_idle();
        checks++;
        if (irq1 !== 1'b1) begin
            errors++;
            $display("FAIL race_setwins: irq1=%b, required 1", irq1);
        end
        set_rd(32'h110, "race_stat", 32'h1, 32'h0);
        tick(); set_wr(32'h110, 32'h1);
        tick(); set_idle();
        checks++;
        if (irq1 !== 1'b0) begin
            errors++;
            $display("FAIL race_clear: irq1=%b, required 0", irq1);
        end
    endtask

    task automatic test_back_to_back_rw();
        tick(); set_wr(32'h108, 32'h001);
        tick(); wr_en = 1'b1; rd_en = 1'b1; addr = 32'h108; wr_data = 32'h002;
        push_exp("rw_old", 32'h001, 1'b1, 32'h001);
        tick(); set_rd(32'h108, "rw_new", 32'h002, 32'h002);
        tick(); set_idle();
    endtask

    task automatic test_reset_abort();
        tick(); rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; addr = 32'h108; wr_data = 32'h155;
        tick(); rst = 1'b0; set_idle();
        checks++;
        if (rd_valid1 !== 1'b0 || rd_data1 !== 32'h0 || gpio_out1 !== 10'h0 || irq1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_dut1: rd_valid=%b rd_data=%h gpio_out=%h irq=%b, required all 0",
                     rd_valid1, rd_data1, gpio_out1, irq1);
        end
        checks++;
        if (rd_valid2 !== 1'b0 || rd_data2 !== 32'h0 || gpio_out2 !== 20'h0 || irq2 !== 1'b0) begin
            errors++;
            $display("FAIL abort_dut2: rd_valid=%b rd_data=%h gpio_out=%h irq=%b, required all 0",
                     rd_valid2, rd_data2, gpio_out2, irq2);
        end
        tick();
        checks++;
        if (gpio_out1 !== 10'h0 || rd_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_after: gpio_out1=%h rd_valid1=%b, required 000 0", gpio_out1, rd_valid1);
        end
        set_rd(32'h108, "abort_out0", 32'h0, 32'h0);
        tick(); set_idle();
    endtask

    initial begin
        test_reset();
        test_out_write();
        test_map();
        test_unselected();
        test_edge_irq();
        test_reset_hold();
        test_w1c_race();
        test_back_to_back_rw();
        test_reset_abort();
        for (int i = 0; i < 8 && sb.size() > 0; i++) tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reads outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
